multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// decode registered on entry to EXEC and a wrapping retire counter.
module multicycle_controller #(
  parameter int ALUOP_W    = 4,
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [31:0]        Instr,
  input  logic               IMemReady,
  input  logic               DMemReady,
  input  logic               Zero,
  output logic               IMemRead,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCSrc,
  output logic               ALUSrc,
  output logic               ALUSrc2,
  output logic               RegSl,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [2:0]         State,
  output logic               IllegalInstr,
  output logic [CNT_W-1:0]   RetireCount
);

  localparam int MW = $clog2(MUL_CYCLES + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        alu_q;
  logic              asrc_q, asrc2_q, rsl_q, rdst_q, m2r_q;
  logic              mul_q, lw_q, sw_q, bne_q;
  logic [MW-1:0]     cnt_q;
  logic [CNT_W-1:0]  rc_q;

  logic [5:0] op, fn;
  logic       dec_ok;
  logic [3:0] dec_alu;
  logic       dec_asrc, dec_asrc2, dec_rsl, dec_rdst, dec_m2r;
  logic       dec_mul, dec_lw, dec_sw, dec_bne;
  logic       unused_instr;

  assign op           = Instr[31:26];
  assign fn           = Instr[5:0];
  assign unused_instr = ^Instr[25:6];

  always_comb begin
    dec_ok    = 1'b1;
    dec_alu   = 4'b0000;
    dec_asrc  = 1'b0;
    dec_asrc2 = 1'b0;
    dec_rsl   = 1'b0;
    dec_rdst  = 1'b0;
    dec_m2r   = 1'b0;
    dec_mul   = 1'b0;
    dec_lw    = 1'b0;
    dec_sw    = 1'b0;
    dec_bne   = 1'b0;
    case (op)
      6'b000000: begin
        dec_rdst = 1'b1;
        case (fn)
          6'b100000: dec_alu = 4'b0000;
          6'b100010: dec_alu = 4'b0001;
          6'b100100: dec_alu = 4'b0011;
          6'b100101: dec_alu = 4'b0100;
          6'b101010: dec_alu = 4'b0101;
          6'b000110: dec_alu = 4'b1010;
          6'b000000, 6'b000010: begin
            dec_alu   = fn[1] ? 4'b1001 : 4'b1000;
            dec_asrc2 = 1'b1;
            dec_rsl   = 1'b1;
          end
          default:   dec_ok  = 1'b0;
        endcase
      end
      6'b011100: begin
        dec_rdst = 1'b1;
        case (fn)
          6'b100001: dec_alu = 4'b1011;
          6'b100000: dec_alu = 4'b1100;
          6'b000010: begin
            dec_alu = 4'b0010;
            dec_mul = 1'b1;
          end
          default:   dec_ok  = 1'b0;
        endcase
      end
      6'b001000: dec_asrc = 1'b1;
      6'b001101: begin
        dec_alu  = 4'b0100;
        dec_asrc = 1'b1;
      end
      6'b100011: begin
        dec_asrc = 1'b1;
        dec_m2r  = 1'b1;
        dec_lw   = 1'b1;
      end
      6'b101011: begin
        dec_asrc = 1'b1;
        dec_sw   = 1'b1;
      end
      6'b000101: begin
        dec_alu  = 4'b0110;
        dec_rdst = 1'b1;
        dec_bne  = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  logic last_exec, br_take, retire;

  assign last_exec = (state_q == S_EXEC) &&
                     (!mul_q || cnt_q == MW'(MUL_CYCLES - 1));
  assign br_take   = last_exec && bne_q && !Zero;
  assign retire    = (last_exec && bne_q) ||
                     (state_q == S_MEM && DMemReady && sw_q) ||
                     (state_q == S_WB);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (IMemReady) state_d = S_DECODE;
      S_DECODE: state_d = dec_ok ? S_EXEC : S_FETCH;
      S_EXEC: begin
        if (last_exec) begin
          if (bne_q)             state_d = S_FETCH;
          else if (lw_q || sw_q) state_d = S_MEM;
          else                   state_d = S_WB;
        end
      end
      S_MEM:    if (DMemReady) state_d = lw_q ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= S_FETCH;
      alu_q   <= '0;
      asrc_q  <= 1'b0;
      asrc2_q <= 1'b0;
      rsl_q   <= 1'b0;
      rdst_q  <= 1'b0;
      m2r_q   <= 1'b0;
      mul_q   <= 1'b0;
      lw_q    <= 1'b0;
      sw_q    <= 1'b0;
      bne_q   <= 1'b0;
      cnt_q   <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE && dec_ok) begin
        alu_q   <= dec_alu;
        asrc_q  <= dec_asrc;
        asrc2_q <= dec_asrc2;
        rsl_q   <= dec_rsl;
        rdst_q  <= dec_rdst;
        m2r_q   <= dec_m2r;
        mul_q   <= dec_mul;
        lw_q    <= dec_lw;
        sw_q    <= dec_sw;
        bne_q   <= dec_bne;
        cnt_q   <= '0;
      end else if (state_q == S_EXEC) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (retire) rc_q <= rc_q + 1'b1;
    end
  end

  // Strobes are gated by Rst so nothing fires while reset is held.
  assign IMemRead     = Rst && state_q == S_FETCH;
  assign IRWrite      = Rst && state_q == S_FETCH && IMemReady;
  assign PCWrite      = Rst && ((state_q == S_FETCH && IMemReady) ||
                                br_take);
  assign PCSrc        = Rst && br_take;
  assign RegWrite     = Rst && state_q == S_WB;
  assign MemRead      = Rst && state_q == S_MEM && lw_q;
  assign MemWrite     = Rst && state_q == S_MEM && sw_q;
  assign IllegalInstr = Rst && state_q == S_DECODE && !dec_ok;

  assign ALUSrc       = asrc_q;
  assign ALUSrc2      = asrc2_q;
  assign RegSl        = rsl_q;
  assign RegDst       = rdst_q;
  assign MemtoReg     = m2r_q;
  assign ALUOp        = ALUOP_W'(alu_q);
  assign State        = state_q;
  assign RetireCount  = rc_q;

endmodule
